// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID pipeline register with stall hold, branch redirect and wrong-path squash.
// Optional STALL_COUNT_EN adds a saturating stall_cycles counter port.
module fetch_stall_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_stall,
  input  logic        IF_ID_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid,
  output logic        ID_bubble
`ifdef STALL_COUNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        fetch_valid, fetch_valid_n;
  logic [31:0] id_instr_n, id_pc_n;
  logic        id_valid_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic        hold_valid, hold_valid_n;
  logic [31:0] src_instr, src_pc;
  logic        src_valid;
  logic        stall;

  assign stall     = pc_stall | IF_ID_stall;
  assign imem_addr = pc;
  assign imem_en   = reset_n;
  assign ID_bubble = IF_ID_stall | ~IF_ID_valid;

  // The fetch that was in flight when a stall began is parked in the hold
  // register, so the PC re-fetch during the stall cannot skip it on release.
  always_comb begin
    if (state == STALL) begin
      src_instr = hold_instr;
      src_pc    = hold_pc;
      src_valid = hold_valid;
    end else begin
      src_instr = imem_rdata;
      src_pc    = fetch_pc;
      src_valid = fetch_valid;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    fetch_pc_n    = fetch_pc;
    fetch_valid_n = fetch_valid;
    id_instr_n    = IF_ID_instr;
    id_pc_n       = IF_ID_pc;
    id_valid_n    = IF_ID_valid;
    hold_instr_n  = hold_instr;
    hold_pc_n     = hold_pc;
    hold_valid_n  = hold_valid;
    unique case (state)
      BOOT: begin
        fetch_pc_n    = pc;
        fetch_valid_n = 1'b1;
        pc_n          = pc + PC_STEP;
        state_n       = RUN;
      end
      RUN, STALL: begin
        if (stall) begin
          fetch_pc_n    = pc;
          fetch_valid_n = 1'b1;
          state_n       = STALL;
          if (state == RUN) begin
            hold_instr_n = imem_rdata;
            hold_pc_n    = fetch_pc;
            hold_valid_n = fetch_valid;
          end
        end else if (branch_taken) begin
          pc_n          = branch_target;
          fetch_pc_n    = pc;
          fetch_valid_n = 1'b0;
          id_instr_n    = NOP_INSTR;
          id_pc_n       = src_pc;
          id_valid_n    = 1'b0;
          state_n       = FLUSH;
        end else begin
          id_instr_n    = src_valid ? src_instr : NOP_INSTR;
          id_pc_n       = src_pc;
          id_valid_n    = src_valid;
          fetch_pc_n    = pc;
          fetch_valid_n = 1'b1;
          pc_n          = pc + PC_STEP;
          state_n       = RUN;
        end
      end
      FLUSH: begin
        id_instr_n    = fetch_valid ? imem_rdata : NOP_INSTR;
        id_pc_n       = fetch_pc;
        id_valid_n    = fetch_valid;
        fetch_pc_n    = pc;
        fetch_valid_n = 1'b1;
        pc_n          = pc + PC_STEP;
        state_n       = RUN;
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc    <= '0;
      IF_ID_valid <= 1'b0;
      hold_instr  <= NOP_INSTR;
      hold_pc     <= '0;
      hold_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fetch_pc    <= fetch_pc_n;
      fetch_valid <= fetch_valid_n;
      IF_ID_instr <= id_instr_n;
      IF_ID_pc    <= id_pc_n;
      IF_ID_valid <= id_valid_n;
      hold_instr  <= hold_instr_n;
      hold_pc     <= hold_pc_n;
      hold_valid  <= hold_valid_n;
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule
